// File: rtl/bitserial_mac_array_if.sv
`default_nettype none
// ============================================================================
// Module  : bitserial_mac_array_if
// Brief   : Operand-in / result-out handshake bundle for bitserial_mac_array.
// Revision: 1.0
// ============================================================================
interface bitserial_mac_array_if #(
    parameter int LANES = 4,
    parameter int ACT_W = 8,
    parameter int WMAX  = 8,
    parameter int ACC_W = 24
);
    localparam int PREC_W = $clog2(WMAX);

    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*ACT_W-1:0]   act;
    logic [LANES*WMAX-1:0]    wgt;
    logic [PREC_W-1:0]        prec;
    logic                     w_signed;
    logic                     last;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*ACC_W-1:0]   out_acc;
    logic                     busy;

    modport master (
        output in_valid, act, wgt, prec, w_signed, last, out_ready,
        input  in_ready, out_valid, out_acc, busy
    );

    modport slave (
        input  in_valid, act, wgt, prec, w_signed, last, out_ready,
        output in_ready, out_valid, out_acc, busy
    );
endinterface
`default_nettype wire

// File: rtl/bitserial_mac_array.sv
`default_nettype none
// ============================================================================
// Module  : bitserial_mac_array
// Brief   : Multi-lane bit-serial MAC; one weight bit per cycle, shared FSM.
// Revision: 1.0
// ============================================================================
module bitserial_mac_array #(
    parameter int LANES = 4,
    parameter int ACT_W = 8,
    parameter int WMAX  = 8,
    parameter int ACC_W = 24
) (
    input  logic                  clk,
    input  logic                  rstn,
    bitserial_mac_array_if.slave  bus
);
    localparam int PREC_W = $clog2(WMAX);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]             r_state;
    logic [PREC_W-1:0]      r_cnt;
    logic [PREC_W-1:0]      r_prec;
    logic                   r_signed;
    logic                   r_last;
    logic [LANES*ACT_W-1:0] r_act;
    logic [LANES*WMAX-1:0]  r_wgt;
    logic [LANES*ACC_W-1:0] r_acc;
    logic [LANES*ACC_W-1:0] r_out;
    logic [LANES*ACC_W-1:0] w_sum;

    logic w_accept;
    logic w_msb_step;
    logic w_run_end;
    logic w_drain;

    assign w_accept   = (r_state == S_IDLE) && bus.in_valid;
    assign w_msb_step = (r_cnt == r_prec);
    assign w_run_end  = (r_state == S_RUN) && w_msb_step;
    assign w_drain    = (r_state == S_OUT) && bus.out_ready;

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_OUT);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.out_acc   = r_out;

    // Per-lane next sum; the top weight bit subtracts when the weight is signed.
    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            logic [WMAX-1:0]  w_wgt;
            logic [ACC_W-1:0] w_ext;
            logic [ACC_W-1:0] w_term;
            logic [ACC_W-1:0] w_acc;

            assign w_wgt  = r_wgt[k*WMAX +: WMAX];
            assign w_acc  = r_acc[k*ACC_W +: ACC_W];
            assign w_ext  = {{(ACC_W-ACT_W){r_act[k*ACT_W+ACT_W-1]}}, r_act[k*ACT_W +: ACT_W]};
            assign w_term = w_wgt[r_cnt] ? (w_ext << r_cnt) : '0;
            assign w_sum[k*ACC_W +: ACC_W] = (r_signed && w_msb_step) ? (w_acc - w_term)
                                                                      : (w_acc + w_term);
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_prec   <= '0;
            r_signed <= 1'b0;
            r_last   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_prec   <= bus.prec;
                        r_signed <= bus.w_signed;
                        r_last   <= bus.last;
                        r_cnt    <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_msb_step) begin
                        r_state <= r_last ? S_OUT : S_IDLE;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_act <= '0;
            r_wgt <= '0;
            r_acc <= '0;
            r_out <= '0;
        end else begin
            if (w_accept) begin
                r_act <= bus.act;
                r_wgt <= bus.wgt;
            end
            if (r_state == S_RUN) begin
                r_acc <= w_sum;
            end else if (w_drain) begin
                r_acc <= '0;
            end
            if (w_run_end && r_last) begin
                r_out <= w_sum;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_bitserial_mac_array.sv
`default_nettype none
// ============================================================================
// Module  : tb_bitserial_mac_array
// Brief   : Directed + random scoreboard bench for bitserial_mac_array.
// Revision: 1.0
// ============================================================================
module tb_bitserial_mac_array;
    localparam int LANES  = 4;
    localparam int ACT_W  = 8;
    localparam int WMAX   = 8;
    localparam int ACC_W  = 24;
    localparam int PREC_W = $clog2(WMAX);
    localparam int OW     = LANES*ACC_W;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    bitserial_mac_array_if #(.LANES(LANES), .ACT_W(ACT_W), .WMAX(WMAX), .ACC_W(ACC_W)) bus ();

    bitserial_mac_array #(.LANES(LANES), .ACT_W(ACT_W), .WMAX(WMAX), .ACC_W(ACC_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int               checks   = 0;
    int               failures = 0;
    logic [ACC_W-1:0] model_acc [LANES];
    logic [OW-1:0]    exp_q [$];
    logic [OW-1:0]    res;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference product: weight value decoded arithmetically, then one multiply.
    function automatic logic [ACC_W-1:0] product(input logic [ACT_W-1:0] a,
                                                 input logic [WMAX-1:0] w,
                                                 input int p, input bit sgn);
        int av;
        int wv;
        av = $signed(a);
        wv = int'(w) & ((1 << (p+1)) - 1);
        if (sgn && w[p]) wv = wv - (1 << (p+1));
        return ACC_W'(av * wv);
    endfunction

    function automatic logic [LANES*ACT_W-1:0] acts(input logic [ACT_W-1:0] a0);
        logic [LANES*ACT_W-1:0] v;
        for (int k = 0; k < LANES; k++) v[k*ACT_W +: ACT_W] = ACT_W'($urandom);
        v[ACT_W-1:0] = a0;
        return v;
    endfunction

    function automatic logic [LANES*WMAX-1:0] wgts(input logic [WMAX-1:0] w0);
        logic [LANES*WMAX-1:0] v;
        for (int k = 0; k < LANES; k++) v[k*WMAX +: WMAX] = WMAX'($urandom);
        v[WMAX-1:0] = w0;
        return v;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", bus.in_ready, 1);
    endtask

    // One operand set; checks RUN timing and scrambles inputs while running.
    task automatic op(input logic [LANES*ACT_W-1:0] a, input logic [LANES*WMAX-1:0] w,
                      input int p, input bit sgn, input bit lst, input bit hold_valid);
        logic [OW-1:0] e;
        wait_ready();
        bus.act      = a;
        bus.wgt      = w;
        bus.prec     = PREC_W'(p);
        bus.w_signed = sgn;
        bus.last     = lst;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < LANES; k++)
            model_acc[k] = model_acc[k] + product(a[k*ACT_W +: ACT_W], w[k*WMAX +: WMAX], p, sgn);
        if (lst) begin
            for (int k = 0; k < LANES; k++) begin
                e[k*ACC_W +: ACC_W] = model_acc[k];
                model_acc[k] = '0;
            end
            exp_q.push_back(e);
        end
        bus.in_valid = hold_valid;
        bus.act      = LANES*ACT_W'($urandom);
        bus.wgt      = LANES*WMAX'($urandom);
        bus.prec     = PREC_W'($urandom);
        bus.w_signed = 1'($urandom);
        bus.last     = 1'($urandom);
        chk("run_busy", bus.busy, 1);
        chk("run_in_ready", bus.in_ready, 0);
        repeat (p) @(negedge clk);
        chk("early_valid", bus.out_valid, 0);
        @(negedge clk);
        chk("latency_valid", bus.out_valid, lst);
        chk("latency_ready", bus.in_ready, !lst);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int stall, output logic [OW-1:0] r);
        int n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_wait", bus.out_valid, 1);
        r = bus.out_acc;
        chk("sb_depth", exp_q.size(), 1);
        if (exp_q.size() != 0) chk("out_acc", bus.out_acc, exp_q.pop_front());
        repeat (stall) begin
            @(negedge clk);
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_stable", bus.out_acc, r);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("post_valid", bus.out_valid, 0);
        chk("post_ready", bus.in_ready, 1);
        chk("post_keep", bus.out_acc, r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int p;
        bit s;
        bit l;
        bus.in_valid = 1'b0; bus.act = '0; bus.wgt = '0; bus.prec = '0;
        bus.w_signed = 1'b0; bus.last = 1'b0; bus.out_ready = 1'b0;
        for (int k = 0; k < LANES; k++) model_acc[k] = '0;
        #2 rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_acc", bus.out_acc, 0);
        rstn = 1'b1;
        @(negedge clk);

        op(acts(8'd11), wgts(8'h09), 7, 1'b1, 1'b1, 1'b0);
        drain(5, res);
        chk("t1_99", res[ACC_W-1:0], 24'd99);

        op(acts(8'd11), wgts(8'hAA), 7, 1'b1, 1'b1, 1'b1);
        drain(0, res);
        chk("t2_neg946", res[ACC_W-1:0], 24'hFFFC4E);
        op(acts(8'd11), wgts(8'hFF), 7, 1'b0, 1'b1, 1'b0);
        drain(1, res);
        chk("t2_2805", res[ACC_W-1:0], 24'd2805);

        op(acts(8'd11), wgts(8'h09), 7, 1'b1, 1'b0, 1'b1);
        op(acts(8'd11), wgts(8'h55), 7, 1'b1, 1'b1, 1'b0);
        drain(2, res);
        chk("t3_1034", res[ACC_W-1:0], 24'd1034);

        op(acts(8'hFD), wgts(8'hF8), 3, 1'b1, 1'b1, 1'b0);
        drain(0, res);
        chk("t4_24", res[ACC_W-1:0], 24'd24);
        op(acts(8'd5), wgts(8'h03), 0, 1'b1, 1'b1, 1'b0);
        drain(0, res);
        chk("t4_neg5", res[ACC_W-1:0], 24'hFFFFFB);

        for (int i = 0; i < 10; i++) begin
            p = $urandom_range(0, WMAX-1);
            s = 1'($urandom);
            l = (i == 9) ? 1'b1 : 1'($urandom);
            op(acts(ACT_W'($urandom)), wgts(WMAX'($urandom)), p, s, l, 1'($urandom));
            if (l) drain($urandom_range(0, 3), res);
        end

        // Abort an operation after three RUN edges.
        wait_ready();
        bus.act = acts(8'd7); bus.wgt = wgts(8'hFF); bus.prec = 3'd7;
        bus.w_signed = 1'b0; bus.last = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_out_acc", bus.out_acc, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        op(acts(8'd2), wgts(8'h03), 1, 1'b0, 1'b1, 1'b0);
        drain(0, res);
        chk("t6_6", res[ACC_W-1:0], 24'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
